io_debounce: RTL and testbench
==============================

# io_debounce

Four-channel input conditioner that sits directly upstream of the `io_sync` priority stage. It takes raw, asynchronous, bouncing button or pin levels and passes each through a two-flop synchronizer and a per-channel stability counter. Its registered output drives the 4-bit `in` bus of the priority stage. Only a level that has been stable for a full debounce window propagates.

## Interface
- `CHANNELS`, default 4: number of independent input channels.
- `DEBOUNCE_CYCLES`, default 250000: consecutive `clk` cycles a new level must persist before it is accepted. Legal range is ≥1.
- `ACTIVE_LOW`, default 0: when 1, raw inputs are inverted before synchronization, so a pressed pull-up button reads as 1.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `raw`, input, `CHANNELS`: asynchronous pin levels.
- `out`, output, `CHANNELS`: debounced levels, registered. Feeds `io_sync.in`.
- `press`, output, `CHANNELS`: only present with `IO_DEBOUNCE_PRESS_EN`. One-cycle press pulses.

## Operation
- **Polarity.** `raw` is XORed with `ACTIVE_LOW` before the synchronizer.
- **Synchronizer.** Each channel has a 2-flop synchronizer: `s1 <= raw`, then `s2 <= s1`.
- **Stability counter.** Each channel has a counter `cnt`, `$clog2(DEBOUNCE_CYCLES+1)` bits wide. It behaves as follows on every clock edge:
  - If `s2 == out[i]`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `out[i] <= s2` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt + 1`.
- **Bounce rejection.** Any return of `s2` to the current `out[i]` clears the count. A bounce shorter than `DEBOUNCE_CYCLES` therefore never reaches `out`.
- **Symmetry.** Press and release use the same window.
- **Channel independence.** Channels are fully independent. Simultaneous changes on several channels each resolve on their own schedule. No cross-channel priority is applied here; the downstream stage does that.
- **Counter range.** The counter saturates by construction and never exceeds `DEBOUNCE_CYCLES-1`. No wrap-around is possible.

## Timing
- **Reset values.** While `rst_n` is low at an edge, all of the following become 0: `s1`, `s2`, `cnt`, `out`, `press`. `raw` is ignored during reset.
- **Latency.** Suppose the post-polarity `raw` settles before edge k and stays stable. Then `out[i]` updates at edge k+`DEBOUNCE_CYCLES`+1:
  - `s1` captures the new level at edge k.
  - `s2` captures it at edge k+1.
  - Counting runs from edge k+2.
- **Example.** With `DEBOUNCE_CYCLES`=1, `out` follows `s2` one edge later, for a total of 2 edges after `raw`.
- **Inputs held through reset.** An input held high through reset release is treated as a fresh change. If the first edge with `rst_n` high is edge r, `out` rises at edge r+`DEBOUNCE_CYCLES`+1.
- **Reset mid-count.** Reset asserted mid-count discards all progress. Counting restarts from zero after release.
- **Glitches.** A single-cycle glitch on `raw` produces at most one cycle of nonzero `cnt` and no `out` change (for `DEBOUNCE_CYCLES` ≥2).

## Configuration
- **Macro.** `IO_DEBOUNCE_PRESS_EN`.
- **Defined.**
  - The `press` port exists.
  - `press[i]` is registered and asserts for exactly one cycle, on the same edge at which `out[i]` transitions 0→1.
  - It stays 0 on 1→0 transitions and at all other times.
- **Undefined.** The `press` port and its logic are absent. `out` behaviour is identical in both builds.

## Structure
- **Package `io_pkg`.** Holds the `IO_CHANNELS` constant (4) and the `io_chan_t` typedef for `logic [IO_CHANNELS-1:0]`, both shared with `io_sync`. It also holds the default debounce-window constant.
- **Sub-module `io_debounce_chan`.** A single channel: polarity XOR, 2-flop synchronizer, counter, output flop, and optional press flop.
- **Top.** Instantiates `io_debounce_chan` with a generate loop over `CHANNELS`.

## Test plan
The bench uses `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=0 unless noted.
- **Reset.** Hold `rst_n`=0 for 3 edges with `raw`=4'hF → `out`=0 and `press`=0 throughout. After release, `out`=4'hF exactly at the 6th edge with `rst_n` high (r+5).
- **Clean press.** `raw[2]` 0→1 before edge k, held → `out`=4'b0100 after edge k+5. With `IO_DEBOUNCE_PRESS_EN` defined, `press`=4'b0100 for that one cycle only.
- **Bounce.** `raw[1]` pattern 1,1,1,0,1,1,1,0 (per cycle) → `out[1]` never rises. Then hold 1 for 6 cycles → `out[1]` rises 5 edges after the last 0→1.
- **Release and simultaneous change.** With `out`=4'b0011, `raw` changes to 4'b1100 at a single edge → all four bits of `out` change on the same edge (k+5). `press` pulses on bits 3:2 only.
- **Reset mid-count.** `raw[0]` rises; pulse `rst_n` low for 1 edge at k+3 → `out[0]` stays 0 and rises at r+5 relative to the release edge.
- **Active-low input.** With `ACTIVE_LOW`=1 and `raw`=4'hE held → `out`=4'h1 after 5 edges.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and types for the io_debounce / io_sync input path.
package io_pkg;

  localparam int IO_CHANNELS = 4;
  localparam int IO_DEBOUNCE_DEFAULT = 250000;

  typedef logic [IO_CHANNELS-1:0] io_chan_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_debounce_chan.sv
// One debounce channel: polarity, 2-flop sync, stability counter, output.
// Optional one-cycle press pulse when IO_DEBOUNCE_PRESS_EN is defined.
module io_debounce_chan
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
`ifdef IO_DEBOUNCE_PRESS_EN
  output logic press,
`endif
  output logic out
);

  localparam int W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic         s1;
  logic         s2;
  logic [W-1:0] cnt;
  logic         pol;

  assign pol = raw ^ POL;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      s1 <= pol;
      s2 <= s1;
      if (s2 == out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        out <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef IO_DEBOUNCE_PRESS_EN
  // Pulse only on the edge where out commits a 0->1 transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press <= 1'b0;
    end else begin
      press <= (s2 != out) && (cnt == LAST) && s2;
    end
  end
`endif

endmodule

// File: rtl/io_debounce.sv
// Multi-channel input debouncer feeding io_sync.in.
// Define IO_DEBOUNCE_PRESS_EN to add the press pulse output.
module io_debounce
  import io_pkg::*;
#(
  parameter int CHANNELS        = IO_CHANNELS,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw,
`ifdef IO_DEBOUNCE_PRESS_EN
  output logic [CHANNELS-1:0] press,
`endif
  output logic [CHANNELS-1:0] out
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    io_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
`ifdef IO_DEBOUNCE_PRESS_EN
      .press(press[i]),
`endif
      .out  (out[i])
    );
  end

endmodule

// File: tb/tb_io_debounce.sv
// Directed self-checking bench for io_debounce, DEBOUNCE_CYCLES=4.
module tb_io_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw;
  logic [3:0] raw_al;
  logic [3:0] out;
  logic [3:0] out_al;
`ifdef IO_DEBOUNCE_PRESS_EN
  logic [3:0] press;
  logic [3:0] press_al;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  io_debounce #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw),
`ifdef IO_DEBOUNCE_PRESS_EN
    .press(press),
`endif
    .out  (out)
  );

  io_debounce #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut_al (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw_al),
`ifdef IO_DEBOUNCE_PRESS_EN
    .press(press_al),
`endif
    .out  (out_al)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%b exp=%b", tag, got, exp);
  endtask

  task automatic chk_press(input string tag, input logic [3:0] exp);
`ifdef IO_DEBOUNCE_PRESS_EN
    chk(tag, press, exp);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    raw    = 4'hF;
    raw_al = 4'hF;

    // Reset held 3 edges with raw high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", out, 4'h0);
      chk_press("rst_press", 4'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rel_wait", out, 4'h0);
    end
    tick();
    chk("rel_rise", out, 4'hF);
    chk_press("rel_press", 4'hF);
    chk("al_idle", out_al, 4'h0);
    tick();
    chk_press("rel_press_end", 4'h0);

    // Back to idle
    raw = 4'h0;
    for (int i = 0; i < 6; i++) tick();
    chk("idle", out, 4'h0);
    chk_press("idle_press", 4'h0);

    // Clean press on bit 2
    raw = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("clean_wait", out, 4'h0);
    end
    tick();
    chk("clean_rise", out, 4'b0100);
    chk_press("clean_press", 4'b0100);
    tick();
    chk_press("clean_press_end", 4'h0);
    chk("clean_hold", out, 4'b0100);

    // Bounce on bit 1: 1,1,1,0,1,1,1,0 never commits
    begin
      logic [7:0] pat;
      pat = 8'b0111_0111;
      for (int j = 0; j < 8; j++) begin
        raw = {2'b01, pat[j], 1'b0};
        tick();
        chk("bounce", out, 4'b0100);
      end
    end
    raw = 4'b0110;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("bounce_hold", out, 4'b0100);
    end
    tick();
    chk("bounce_rise", out, 4'b0110);
    chk_press("bounce_press", 4'b0010);

    // Establish 0011
    raw = 4'b0011;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_simul", out, 4'b0011);

    // Simultaneous change 0011 -> 1100
    raw = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("simul_wait", out, 4'b0011);
      chk_press("simul_press_wait", 4'h0);
    end
    tick();
    chk("simul_flip", out, 4'b1100);
    chk_press("simul_press", 4'b1100);
    tick();
    chk_press("simul_press_end", 4'h0);

    // Reset mid-count on bit 0
    raw = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_wait", out, 4'b1100);
    end
    rst_n = 1'b0;
    tick();
    chk("mid_rst", out, 4'h0);
    chk_press("mid_rst_press", 4'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rel_wait", out, 4'h0);
    end
    tick();
    chk("mid_rel_rise", out, 4'b1101);
    chk_press("mid_rel_press", 4'b1101);

    // Active-low instance: raw=E reads as 1 on bit 0
    raw_al = 4'hE;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("al_wait", out_al, 4'h0);
    end
    tick();
    chk("al_rise", out_al, 4'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
